// File: rtl/hilo_mul_unit_pkg.sv
// Shared definitions for the HI/LO multiply unit: widths, alucontrol codes and FSM states.
// Optional build macro HILO_EARLY_TERM_EN is consumed by hilo_mul_core.
package hilo_mul_unit_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 6;

  localparam logic [4:0] MULT_CONTROL  = 5'b10000;
  localparam logic [4:0] MULTU_CONTROL = 5'b10001;
  localparam logic [4:0] MTHI_CONTROL  = 5'b10010;
  localparam logic [4:0] MTLO_CONTROL  = 5'b10011;
  localparam logic [4:0] MFHI_CONTROL  = 5'b10100;
  localparam logic [4:0] MFLO_CONTROL  = 5'b10101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic             signed_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } mul_req_t;

  function automatic logic is_mul(input logic [4:0] code);
    return (code == MULT_CONTROL) || (code == MULTU_CONTROL);
  endfunction

endpackage

// File: rtl/hilo_mul_unit_if.sv
// E-stage request/response bundle between the pipeline and the HI/LO multiply unit.
interface hilo_mul_unit_if;
  import hilo_mul_unit_pkg::*;

  logic [4:0]       alucontrol;
  logic             start;
  logic             flush;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             stall_e;
  logic             done;
  logic [WIDTH-1:0] hilo_result;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output alucontrol, start, flush, srca, srcb,
    input  stall_e, done, hilo_result, hi, lo
  );

  modport slave (
    input  alucontrol, start, flush, srca, srcb,
    output stall_e, done, hilo_result, hi, lo
  );

endinterface

// File: rtl/hilo_mul_unit_core.sv
// Shift-add multiplier datapath: operand magnitudes, {acc, mplr} product register, counter, sign fix-up.
// With HILO_EARLY_TERM_EN the iteration stops once the remaining multiplier bits are zero.
module hilo_mul_core
  import hilo_mul_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  mul_req_t           i_req,
  input  logic               i_step,
  output logic               o_last_c,
  output logic [2*WIDTH-1:0] o_product_c
);

  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_mplr;
  logic               r_neg;
  logic [CNT_W-1:0]   r_cnt;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH-1:0]   w_mplr_nxt;
  logic [2*WIDTH-1:0] w_raw;
  logic               w_rest_zero;

  always_comb begin
    w_a_mag    = (i_req.signed_op && i_req.a[WIDTH-1]) ? -i_req.a : i_req.a;
    w_b_mag    = (i_req.signed_op && i_req.b[WIDTH-1]) ? -i_req.b : i_req.b;
    // Carry of the add lands in acc's MSB after the shift.
    w_sum      = {1'b0, r_acc} + (r_mplr[0] ? {1'b0, r_mcand} : '0);
    w_acc_nxt  = w_sum[WIDTH:1];
    w_mplr_nxt = {w_sum[0], r_mplr[WIDTH-1:1]};
  end

`ifdef HILO_EARLY_TERM_EN
  // After this step the low (WIDTH-1-r_cnt) bits of mplr are still unconsumed multiplier.
  always_comb begin
    w_rest_zero = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (((i + int'(r_cnt)) < (int'(WIDTH) - 1)) && w_mplr_nxt[i]) w_rest_zero = 1'b0;
    end
  end

  assign o_last_c = (r_cnt == CNT_W'(WIDTH - 1)) || w_rest_zero;
  assign w_raw    = {r_acc, r_mplr} >> (CNT_W'(WIDTH) - r_cnt);
`else
  assign w_rest_zero = 1'b0;
  assign o_last_c    = (r_cnt == CNT_W'(WIDTH - 1)) || w_rest_zero;
  assign w_raw       = {r_acc, r_mplr};
`endif

  assign o_product_c = r_neg ? -w_raw : w_raw;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mcand <= '0;
      r_acc   <= '0;
      r_mplr  <= '0;
      r_neg   <= 1'b0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_mcand <= w_a_mag;
      r_acc   <= '0;
      r_mplr  <= w_b_mag;
      r_neg   <= i_req.signed_op & (i_req.a[WIDTH-1] ^ i_req.b[WIDTH-1]);
      r_cnt   <= '0;
    end else if (i_step) begin
      r_acc   <= w_acc_nxt;
      r_mplr  <= w_mplr_nxt;
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hilo_mul_unit.sv
// HI/LO unit: issue/iterate/commit FSM, architectural HI/LO registers and MFHI/MFLO read mux.
// Build macro HILO_EARLY_TERM_EN (in hilo_mul_core) enables data-dependent multiply latency.
module hilo_mul_unit
  import hilo_mul_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  hilo_mul_unit_if.slave  bus
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_load;
  logic               w_step;
  logic               w_commit;
  logic               w_wr_hi;
  logic               w_wr_lo;
  logic               w_last;
  logic [2*WIDTH-1:0] w_product;
  mul_req_t           w_req;

  always_comb begin
    w_req.signed_op = (bus.alucontrol == MULT_CONTROL);
    w_req.a         = bus.srca;
    w_req.b         = bus.srcb;
  end

  hilo_mul_core u_core (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_req       (w_req),
    .i_step      (w_step),
    .o_last_c    (w_last),
    .o_product_c (w_product)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_commit    = 1'b0;
    w_wr_hi     = 1'b0;
    w_wr_lo     = 1'b0;
    bus.stall_e = 1'b0;
    bus.done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          if (is_mul(bus.alucontrol)) begin
            w_load      = 1'b1;
            bus.stall_e = 1'b1;
            w_state_nxt = S_MUL;
          end else if (bus.alucontrol == MTHI_CONTROL) begin
            w_wr_hi = 1'b1;
          end else if (bus.alucontrol == MTLO_CONTROL) begin
            w_wr_lo = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (bus.flush) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_step      = 1'b1;
          bus.stall_e = 1'b1;
          if (w_last) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // start still belongs to the completing multiply, so it is not decoded here.
        w_state_nxt = S_IDLE;
        if (!bus.flush) begin
          bus.done = 1'b1;
          w_commit = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      r_hi <= w_product[2*WIDTH-1:WIDTH];
      r_lo <= w_product[WIDTH-1:0];
    end else begin
      if (w_wr_hi) r_hi <= bus.srca;
      if (w_wr_lo) r_lo <= bus.srca;
    end
  end

  always_comb begin
    bus.hilo_result = '0;
    if (bus.alucontrol == MFHI_CONTROL)      bus.hilo_result = r_hi;
    else if (bus.alucontrol == MFLO_CONTROL) bus.hilo_result = r_lo;
  end

  assign bus.hi = r_hi;
  assign bus.lo = r_lo;

endmodule

// File: tb/tb_hilo_mul_unit.sv
// Randomized self-checking bench for hilo_mul_unit against a transaction-level HI/LO model.
module tb_hilo_mul_unit;
  import hilo_mul_unit_pkg::*;

  localparam logic [4:0] OTHER_CONTROL = 5'b00010;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hilo_mul_unit_if bus();
  hilo_mul_unit dut (.clk(clk), .rst(rst), .bus(bus));

  int          n_chk = 0;
  int          n_pass = 0;
  logic        chk_en = 1'b0;
  logic        e_stall, e_done;
  logic [31:0] e_res, m_hi, m_lo;
  int          stall_cnt = 0;
  int          done_cnt = 0;
  logic [4:0]  codes [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall_e", 64'(bus.stall_e), 64'(e_stall));
      chk("done", 64'(bus.done), 64'(e_done));
      chk("hilo_result", 64'(bus.hilo_result), 64'(e_res));
      chk("hi", 64'(bus.hi), 64'(m_hi));
      chk("lo", 64'(bus.lo), 64'(m_lo));
      if (bus.stall_e) stall_cnt++;
      if (bus.done) done_cnt++;
    end
  end

  function automatic logic [63:0] ref_prod(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    if (sgn) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic int n_iter(input logic sgn, input logic [31:0] b);
`ifdef HILO_EARLY_TERM_EN
    logic [31:0] m;
    int n;
    m = (sgn && b[31]) ? -b : b;
    n = 1;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    return n;
`else
    return 32 + (sgn ? 0 : int'(b[0] & 1'b0));
`endif
  endfunction

  task automatic drive(input logic [4:0] c, input logic st, input logic fl,
                       input logic [31:0] a, input logic [31:0] b, input logic es, input logic ed);
    bus.alucontrol = c;
    bus.start      = st;
    bus.flush      = fl;
    bus.srca       = a;
    bus.srcb       = b;
    e_stall        = es;
    e_done         = ed;
    e_res          = (c == MFHI_CONTROL) ? m_hi : (c == MFLO_CONTROL) ? m_lo : 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One instruction; fl_at is the cycle index (0 = issue) carrying flush, -1 for none.
  task automatic run_op(input logic [4:0] c, input logic st, input logic [31:0] a,
                        input logic [31:0] b, input int fl_at);
    bit mul;
    int n;
    bit fl;
    mul = st && is_mul(c);
    if (!mul) begin
      drive(c, st, fl_at == 0, a, b, 1'b0, 1'b0);
      tick();
      if (st && fl_at != 0) begin
        if (c == MTHI_CONTROL) m_hi = a;
        else if (c == MTLO_CONTROL) m_lo = a;
      end
    end else begin
      n = n_iter(c == MULT_CONTROL, b);
      for (int k = 0; k <= n + 1; k++) begin
        fl = (k == fl_at);
        drive(c, 1'b1, fl, a, b, (k <= n) && !fl, (k == n + 1) && !fl);
        tick();
        if (fl) return;
      end
      {m_hi, m_lo} = ref_prod(c == MULT_CONTROL, a, b);
    end
  endtask

  task automatic rd(input logic [4:0] c, input logic [31:0] exp, input string nm);
    drive(c, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    chk(nm, 64'(bus.hilo_result), 64'(exp));
    tick();
  endtask

  initial begin
    int          fk;
    int          sel;
    int          fl;
    logic [4:0]  c;
    logic [31:0] a, b;
    logic        st;

    codes = '{MULT_CONTROL, MULTU_CONTROL, MTHI_CONTROL, MTLO_CONTROL,
              MFHI_CONTROL, MFLO_CONTROL, OTHER_CONTROL};
    m_hi = '0;
    m_lo = '0;
    drive(MFHI_CONTROL, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b1;
    chk("rst_hi", 64'(bus.hi), 64'h0);
    chk("rst_lo", 64'(bus.lo), 64'h0);

    // Unsigned max*max.
    stall_cnt = 0; done_cnt = 0;
    run_op(MULTU_CONTROL, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    chk("multu_max_stall_cycles", 64'(stall_cnt), 64'd33);
    chk("multu_max_done_pulses", 64'(done_cnt), 64'd1);
    rd(MFHI_CONTROL, 32'hFFFF_FFFE, "multu_max_mfhi");
    rd(MFLO_CONTROL, 32'h0000_0001, "multu_max_mflo");

    // Signed corner cases.
    run_op(MULT_CONTROL, 1'b1, 32'h8000_0000, 32'h8000_0000, -1);
    chk("mult_minmin", {32'(bus.hi), 32'(bus.lo)}, 64'h4000_0000_0000_0000);
    run_op(MULT_CONTROL, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, -1);
    chk("mult_m1_p1", {32'(bus.hi), 32'(bus.lo)}, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(MULT_CONTROL, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    chk("mult_m1_m1", {32'(bus.hi), 32'(bus.lo)}, 64'h0000_0000_0000_0001);

    // Back-to-back MTHI/MTLO, no stall.
    stall_cnt = 0;
    run_op(MTHI_CONTROL, 1'b1, 32'h1234_5678, 32'h0, -1);
    run_op(MTLO_CONTROL, 1'b1, 32'h9ABC_DEF0, 32'h0, -1);
    chk("mthi_mtlo_stall_cycles", 64'(stall_cnt), 64'd0);
    rd(MFHI_CONTROL, 32'h1234_5678, "mthi_mfhi");
    rd(MFLO_CONTROL, 32'h9ABC_DEF0, "mtlo_mflo");

    // Flush mid-multiply leaves HI/LO alone.
    fk = (n_iter(1'b1, 32'd6) >= 10) ? 10 : 2;
    done_cnt = 0;
    run_op(MULT_CONTROL, 1'b1, 32'd7, 32'd6, fk);
    chk("flush_mul_done_pulses", 64'(done_cnt), 64'd0);
    chk("flush_mul_hilo", {32'(bus.hi), 32'(bus.lo)}, 64'h1234_5678_9ABC_DEF0);

    // Flush at issue, flush in DONE, flushed MTHI.
    run_op(MULTU_CONTROL, 1'b1, 32'd3, 32'd3, 0);
    run_op(MULTU_CONTROL, 1'b1, 32'd3, 32'd3, n_iter(1'b0, 32'd3) + 1);
    run_op(MTHI_CONTROL, 1'b1, 32'hDEAD_BEEF, 32'h0, 0);
    chk("flush_misc_hilo", {32'(bus.hi), 32'(bus.lo)}, 64'h1234_5678_9ABC_DEF0);

    // Small multiplier: early-terminating when the feature is built in.
    stall_cnt = 0; done_cnt = 0;
    run_op(MULTU_CONTROL, 1'b1, 32'd5, 32'd3, -1);
`ifdef HILO_EARLY_TERM_EN
    chk("multu_5x3_stall_cycles", 64'(stall_cnt), 64'd3);
`else
    chk("multu_5x3_stall_cycles", 64'(stall_cnt), 64'd33);
`endif
    chk("multu_5x3_done_pulses", 64'(done_cnt), 64'd1);
    chk("multu_5x3_hilo", {32'(bus.hi), 32'(bus.lo)}, 64'd15);

    stall_cnt = 0;
    run_op(MULT_CONTROL, 1'b1, 32'hFFFF_FFF9, 32'd0, -1);
`ifdef HILO_EARLY_TERM_EN
    chk("mult_by_zero_stall_cycles", 64'(stall_cnt), 64'd2);
`else
    chk("mult_by_zero_stall_cycles", 64'(stall_cnt), 64'd33);
`endif
    chk("mult_by_zero_hilo", {32'(bus.hi), 32'(bus.lo)}, 64'd0);

    // Reset in the middle of a multiply clears HI/LO.
    run_op(MTHI_CONTROL, 1'b1, 32'hCAFE_0001, 32'h0, -1);
    drive(MULT_CONTROL, 1'b1, 1'b0, 32'd9, 32'hF000_0000, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    chk_en = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    m_hi = '0;
    m_lo = '0;
    chk_en = 1'b1;
    run_op(MFHI_CONTROL, 1'b0, 32'h0, 32'h0, -1);
    chk("rst_mid_mul_hi", 64'(bus.hi), 64'h0);

    // Randomized mix.
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 6));
      c   = codes[sel];
      a   = $urandom;
      b   = $urandom;
      if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(0, 300));
      if ($urandom_range(0, 4) == 0) b = -b;
      st  = ($urandom_range(0, 5) != 0);
      fl  = -1;
      if ($urandom_range(0, 7) == 0)
        fl = int'($urandom_range(0, 32'(n_iter(c == MULT_CONTROL, b) + 1)));
      run_op(c, st, a, b, fl);
    end

    run_op(OTHER_CONTROL, 1'b0, 32'h0, 32'h0, -1);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
